// File: rtl/blk_rx_pkg.sv
// Shared encodings and defaults for the framed UART receiver.
package blk_rx_pkg;

   localparam int unsigned BYTE_W  = 8;
   localparam int unsigned LEN_W   = 8;
   localparam int unsigned STAT_W  = 3;
   localparam int unsigned MIN_LEN = 5;

   localparam logic [BYTE_W-1:0] DEF_HDR0 = 8'h30;
   localparam logic [BYTE_W-1:0] DEF_HDR1 = 8'h31;
   localparam logic [BYTE_W-1:0] DEF_TRL  = 8'h32;

   typedef enum logic [2:0] {
      S_HUNT,
      S_HDR1,
      S_LEN,
      S_BODY,
      S_CHK,
      S_TRL,
      S_COPY_OK,
      S_COPY_FAIL
   } state_e;

   typedef enum logic [STAT_W-1:0] {
      ST_OK  = 3'd0,
      ST_HDR = 3'd1,
      ST_LEN = 3'd2,
      ST_CHK = 3'd3,
      ST_TRL = 3'd4,
      ST_TMO = 3'd5
   } status_e;

   // True while the buffered frame is being copied out.
   function automatic logic is_copy(input state_e s);
      return (s == S_COPY_OK) || (s == S_COPY_FAIL);
   endfunction

endpackage

// File: rtl/blk_rx_copier.sv
// Byte-serial copy engine: streams buffer[0..len-1] to the selected memory port.
module blk_rx_copier
   import blk_rx_pkg::*;
#(
   parameter int unsigned MEM_AW = 10
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   input  logic              sel_ok,
   output logic [LEN_W-1:0]  rd_addr_c,
   input  logic [BYTE_W-1:0] rd_data,
   output logic              last_c,
   output logic              ok_en,
   output logic              ok_wen,
   output logic [MEM_AW-1:0] ok_waddr,
   output logic [BYTE_W-1:0] ok_wdata,
   output logic              ok_wdone,
   output logic [MEM_AW-1:0] ok_byte,
   output logic              fail_en,
   output logic              fail_wen,
   output logic [MEM_AW-1:0] fail_waddr,
   output logic [BYTE_W-1:0] fail_wdata,
   output logic              fail_wdone,
   output logic [MEM_AW-1:0] fail_byte
);

   logic             active_q;
   logic             sel_q;
   logic [LEN_W-1:0] cnt_q;
   logic [LEN_W-1:0] len_q;

   assign rd_addr_c = cnt_q;
   assign last_c    = active_q && (cnt_q == len_q);

   // One write per cycle, then a single done cycle; idle port stays quiet.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         active_q   <= 1'b0;
         sel_q      <= 1'b0;
         cnt_q      <= '0;
         len_q      <= '0;
         ok_en      <= 1'b0;
         ok_wen     <= 1'b0;
         ok_waddr   <= '0;
         ok_wdata   <= '0;
         ok_wdone   <= 1'b0;
         ok_byte    <= '0;
         fail_en    <= 1'b0;
         fail_wen   <= 1'b0;
         fail_waddr <= '0;
         fail_wdata <= '0;
         fail_wdone <= 1'b0;
         fail_byte  <= '0;
      end else begin
         ok_en      <= 1'b0;
         ok_wen     <= 1'b0;
         ok_waddr   <= '0;
         ok_wdata   <= '0;
         ok_wdone   <= 1'b0;
         fail_en    <= 1'b0;
         fail_wen   <= 1'b0;
         fail_waddr <= '0;
         fail_wdata <= '0;
         fail_wdone <= 1'b0;
         if (start) begin
            active_q <= 1'b1;
            cnt_q    <= '0;
            len_q    <= len;
            sel_q    <= sel_ok;
         end else if (active_q) begin
            if (cnt_q != len_q) begin
               cnt_q <= cnt_q + LEN_W'(1);
               if (sel_q) begin
                  ok_en    <= 1'b1;
                  ok_wen   <= 1'b1;
                  ok_waddr <= MEM_AW'(cnt_q);
                  ok_wdata <= rd_data;
               end else begin
                  fail_en    <= 1'b1;
                  fail_wen   <= 1'b1;
                  fail_waddr <= MEM_AW'(cnt_q);
                  fail_wdata <= rd_data;
               end
            end else begin
               active_q <= 1'b0;
               if (sel_q) begin
                  ok_wdone <= 1'b1;
                  ok_byte  <= MEM_AW'(len_q);
               end else begin
                  fail_wdone <= 1'b1;
                  fail_byte  <= MEM_AW'(len_q);
               end
            end
         end
      end
   end

endmodule

// File: rtl/blk_rx_frame.sv
// Frame parser/router: [H0][H1][LEN][payload][CHK][TRL] -> OK or FAIL memory port.
module blk_rx_frame
   import blk_rx_pkg::*;
#(
   parameter logic [7:0]  HDR0    = DEF_HDR0,
   parameter logic [7:0]  HDR1    = DEF_HDR1,
   parameter logic [7:0]  TRL     = DEF_TRL,
   parameter int unsigned MAX_LEN = 100,
   parameter int unsigned MEM_AW  = 10,
   parameter int unsigned TIMEOUT = 1000,
   parameter int unsigned CNT_W   = 16
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_rx_dv,
   input  logic [7:0]        i_rx_byte,
   output logic              o_ok_mem_en,
   output logic              o_ok_mem_wen,
   output logic [MEM_AW-1:0] o_ok_mem_waddr,
   output logic [7:0]        o_ok_mem_wdata,
   output logic              o_ok_mem_wdone,
   output logic [MEM_AW-1:0] o_ok_mem_byte,
   output logic              o_fail_mem_en,
   output logic              o_fail_mem_wen,
   output logic [MEM_AW-1:0] o_fail_mem_waddr,
   output logic [7:0]        o_fail_mem_wdata,
   output logic              o_fail_mem_wdone,
   output logic [MEM_AW-1:0] o_fail_mem_byte,
   output logic              o_led,
   output logic              o_busy,
   output logic [2:0]        o_status,
   output logic [CNT_W-1:0]  o_ok_cnt,
   output logic [CNT_W-1:0]  o_err_cnt,
   output logic [CNT_W-1:0]  o_drop_cnt
);

   localparam int unsigned TMR_W  = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam int unsigned BUF_AW = $clog2(MAX_LEN);

   state_e            state_q, state_n;
   status_e           pend_q, pend_n;
   logic [LEN_W-1:0]  copy_len_q, copy_len_n;
   logic [LEN_W-1:0]  idx_q, len_q;
   logic [BYTE_W-1:0] chk_q;
   logic              chk_bad_q;
   logic [TMR_W-1:0]  timer_q;
   logic              start_q;
   logic [BYTE_W-1:0] buf_q [2**BUF_AW];

   logic              accept_c, parse_c, tmo_c, len_ok_c, wr_c, enter_copy_c, last_c;
   logic [LEN_W-1:0]  rd_addr_c;

   assign accept_c     = i_rx_dv && !is_copy(state_q);
   assign parse_c      = (state_q != S_HUNT) && !is_copy(state_q);
   assign tmo_c        = (TIMEOUT != 0) && parse_c && (timer_q == TMR_W'(TIMEOUT));
   assign len_ok_c     = (i_rx_byte >= 8'(MIN_LEN)) && (i_rx_byte <= 8'(MAX_LEN));
   assign wr_c         = accept_c && ((state_q != S_HUNT) || (i_rx_byte == HDR0));
   assign enter_copy_c = is_copy(state_n) && !is_copy(state_q);

   // Parser next-state and the result/length to hand to the copier.
   always_comb begin
      state_n    = state_q;
      pend_n     = pend_q;
      copy_len_n = copy_len_q;
      if (tmo_c && !accept_c) begin
         state_n    = S_COPY_FAIL;
         pend_n     = ST_TMO;
         copy_len_n = idx_q;
      end else begin
         case (state_q)
            S_HUNT: begin
               if (accept_c && (i_rx_byte == HDR0)) state_n = S_HDR1;
            end
            S_HDR1: begin
               if (accept_c) begin
                  if (i_rx_byte == HDR1) begin
                     state_n = S_LEN;
                  end else begin
                     state_n    = S_COPY_FAIL;
                     pend_n     = ST_HDR;
                     copy_len_n = LEN_W'(2);
                  end
               end
            end
            S_LEN: begin
               if (accept_c) begin
                  if (len_ok_c) begin
                     state_n = (i_rx_byte == 8'(MIN_LEN)) ? S_CHK : S_BODY;
                  end else begin
                     state_n    = S_COPY_FAIL;
                     pend_n     = ST_LEN;
                     copy_len_n = LEN_W'(3);
                  end
               end
            end
            S_BODY: begin
               if (accept_c && (idx_q == len_q - LEN_W'(3))) state_n = S_CHK;
            end
            S_CHK: begin
               if (accept_c) state_n = S_TRL;
            end
            S_TRL: begin
               if (accept_c) begin
                  copy_len_n = len_q;
                  if (i_rx_byte != TRL) begin
                     state_n = S_COPY_FAIL;
                     pend_n  = ST_TRL;
                  end else if (chk_bad_q) begin
                     state_n = S_COPY_FAIL;
                     pend_n  = ST_CHK;
                  end else begin
                     state_n = S_COPY_OK;
                     pend_n  = ST_OK;
                  end
               end
            end
            S_COPY_OK, S_COPY_FAIL: begin
               if (last_c) state_n = S_HUNT;
            end
            default: state_n = S_HUNT;
         endcase
      end
   end

   // Parser state register.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) state_q <= S_HUNT;
      else          state_q <= state_n;
   end

   // Frame buffer; contents are don't-care until written.
   always_ff @(posedge i_clk) begin
      if (wr_c) buf_q[BUF_AW'(idx_q)] <= i_rx_byte;
   end

   // Parse datapath, copy handshake, status and statistics.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         pend_q     <= ST_OK;
         copy_len_q <= '0;
         idx_q      <= '0;
         len_q      <= '0;
         chk_q      <= '0;
         chk_bad_q  <= 1'b0;
         timer_q    <= '0;
         start_q    <= 1'b0;
         o_busy     <= 1'b0;
         o_status   <= '0;
         o_led      <= 1'b0;
         o_ok_cnt   <= '0;
         o_err_cnt  <= '0;
         o_drop_cnt <= '0;
      end else begin
         pend_q     <= pend_n;
         copy_len_q <= copy_len_n;
         start_q    <= enter_copy_c;
         o_busy     <= is_copy(state_n);
         if (!parse_c || accept_c) timer_q <= '0;
         else                      timer_q <= timer_q + TMR_W'(1);
         if (enter_copy_c) begin
            idx_q     <= '0;
            chk_q     <= '0;
            chk_bad_q <= 1'b0;
         end else if (wr_c) begin
            idx_q <= idx_q + LEN_W'(1);
            if (state_q != S_CHK && state_q != S_TRL) chk_q <= chk_q ^ i_rx_byte;
            if (state_q == S_LEN) len_q <= i_rx_byte;
            if (state_q == S_CHK) chk_bad_q <= (i_rx_byte != chk_q);
         end
         if (last_c) begin
            o_status <= pend_q;
            if (state_q == S_COPY_OK) begin
               o_led <= ~o_led;
               if (o_ok_cnt != '1) o_ok_cnt <= o_ok_cnt + CNT_W'(1);
            end else begin
               if (o_err_cnt != '1) o_err_cnt <= o_err_cnt + CNT_W'(1);
            end
         end
         if (i_rx_dv && is_copy(state_q) && (o_drop_cnt != '1)) begin
            o_drop_cnt <= o_drop_cnt + CNT_W'(1);
         end
      end
   end

   blk_rx_copier #(.MEM_AW(MEM_AW)) u_copier (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .start      (start_q),
      .len        (copy_len_q),
      .sel_ok     (state_q == S_COPY_OK),
      .rd_addr_c  (rd_addr_c),
      .rd_data    (buf_q[BUF_AW'(rd_addr_c)]),
      .last_c     (last_c),
      .ok_en      (o_ok_mem_en),
      .ok_wen     (o_ok_mem_wen),
      .ok_waddr   (o_ok_mem_waddr),
      .ok_wdata   (o_ok_mem_wdata),
      .ok_wdone   (o_ok_mem_wdone),
      .ok_byte    (o_ok_mem_byte),
      .fail_en    (o_fail_mem_en),
      .fail_wen   (o_fail_mem_wen),
      .fail_waddr (o_fail_mem_waddr),
      .fail_wdata (o_fail_mem_wdata),
      .fail_wdone (o_fail_mem_wdone),
      .fail_byte  (o_fail_mem_byte)
   );

endmodule

// File: tb/tb_blk_rx_frame.sv
// Scoreboard bench for blk_rx_frame: stimulus pushes expected port activity,
// a negedge monitor pops and compares whenever either memory port is active.
module tb_blk_rx_frame;

   localparam int MEM_AW = 10;
   localparam int CNT_W  = 16;
   localparam int TMO    = 20;

   logic              i_clk = 1'b0;
   logic              i_reset;
   logic              i_rx_dv;
   logic [7:0]        i_rx_byte;
   logic              o_ok_mem_en, o_ok_mem_wen, o_ok_mem_wdone;
   logic [MEM_AW-1:0] o_ok_mem_waddr, o_ok_mem_byte;
   logic [7:0]        o_ok_mem_wdata;
   logic              o_fail_mem_en, o_fail_mem_wen, o_fail_mem_wdone;
   logic [MEM_AW-1:0] o_fail_mem_waddr, o_fail_mem_byte;
   logic [7:0]        o_fail_mem_wdata;
   logic              o_led, o_busy;
   logic [2:0]        o_status;
   logic [CNT_W-1:0]  o_ok_cnt, o_err_cnt, o_drop_cnt;

   always #5 i_clk = ~i_clk;

   blk_rx_frame #(.TIMEOUT(TMO), .MEM_AW(MEM_AW), .CNT_W(CNT_W)) dut (
      .i_clk            (i_clk),
      .i_reset          (i_reset),
      .i_rx_dv          (i_rx_dv),
      .i_rx_byte        (i_rx_byte),
      .o_ok_mem_en      (o_ok_mem_en),
      .o_ok_mem_wen     (o_ok_mem_wen),
      .o_ok_mem_waddr   (o_ok_mem_waddr),
      .o_ok_mem_wdata   (o_ok_mem_wdata),
      .o_ok_mem_wdone   (o_ok_mem_wdone),
      .o_ok_mem_byte    (o_ok_mem_byte),
      .o_fail_mem_en    (o_fail_mem_en),
      .o_fail_mem_wen   (o_fail_mem_wen),
      .o_fail_mem_waddr (o_fail_mem_waddr),
      .o_fail_mem_wdata (o_fail_mem_wdata),
      .o_fail_mem_wdone (o_fail_mem_wdone),
      .o_fail_mem_byte  (o_fail_mem_byte),
      .o_led            (o_led),
      .o_busy           (o_busy),
      .o_status         (o_status),
      .o_ok_cnt         (o_ok_cnt),
      .o_err_cnt        (o_err_cnt),
      .o_drop_cnt       (o_drop_cnt)
   );

   typedef struct {
      int done;
      int ok;
      int addr;
      int data;
      int nbytes;
      int status;
      int okc;
      int errc;
      int led;
      int lat;
   } exp_t;

   exp_t       q[$];
   logic [7:0] frm[$];
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_cyc = 0;
   int stray_done = 0;
   int exp_ok = 0;
   int exp_err = 0;
   int exp_led = 0;
   bit mon_off = 1'b0;

   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: every active port cycle consumes one scoreboard entry.
   always @(negedge i_clk) begin : mon
      exp_t e;
      if (i_reset && !mon_off &&
          (o_ok_mem_en || o_fail_mem_en || o_ok_mem_wdone || o_fail_mem_wdone)) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: ok_en=%0d fail_en=%0d ok_done=%0d fail_done=%0d",
                     o_ok_mem_en, o_fail_mem_en, o_ok_mem_wdone, o_fail_mem_wdone);
         end else begin
            e = q.pop_front();
            if (e.done == 0) begin
               check("wr_ok_en", int'(o_ok_mem_en), e.ok);
               check("wr_fail_en", int'(o_fail_mem_en), 1 - e.ok);
               if (e.ok != 0) begin
                  check("ok_wen", int'(o_ok_mem_wen), 1);
                  check("ok_waddr", int'(o_ok_mem_waddr), e.addr);
                  check("ok_wdata", int'(o_ok_mem_wdata), e.data);
               end else begin
                  check("fail_wen", int'(o_fail_mem_wen), 1);
                  check("fail_waddr", int'(o_fail_mem_waddr), e.addr);
                  check("fail_wdata", int'(o_fail_mem_wdata), e.data);
               end
            end else begin
               check("ok_wdone", int'(o_ok_mem_wdone), e.ok);
               check("fail_wdone", int'(o_fail_mem_wdone), 1 - e.ok);
               check("done_byte", (e.ok != 0) ? int'(o_ok_mem_byte) : int'(o_fail_mem_byte), e.nbytes);
               check("done_en_low", int'(o_ok_mem_en | o_fail_mem_en), 0);
               check("status", int'(o_status), e.status);
               check("ok_cnt", int'(o_ok_cnt), e.okc);
               check("err_cnt", int'(o_err_cnt), e.errc);
               check("led", int'(o_led), e.led);
               if (e.lat >= 0) check("latency", cyc - last_cyc, e.lat);
            end
         end
      end
      if (mon_off && (o_ok_mem_wdone || o_fail_mem_wdone)) stray_done++;
   end

   task automatic send_byte(input logic [7:0] b, input bit rec);
      @(negedge i_clk);
      i_rx_dv   = 1'b1;
      i_rx_byte = b;
      @(negedge i_clk);
      i_rx_dv   = 1'b0;
      if (rec) last_cyc = cyc;
   endtask

   // Queue expected writes of frm[skip +: n] plus the done cycle, then send frm.
   task automatic run_frame(input int ok, input int skip, input int n, input int st);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.done = 0; e.ok = ok; e.addr = i; e.data = int'(frm[skip + i]);
         e.nbytes = 0; e.status = 0; e.okc = 0; e.errc = 0; e.led = 0; e.lat = -1;
         q.push_back(e);
      end
      if (ok != 0) begin
         exp_ok++;
         exp_led = 1 - exp_led;
      end else begin
         exp_err++;
      end
      e.done = 1; e.ok = ok; e.addr = 0; e.data = 0; e.nbytes = n; e.status = st;
      e.okc = exp_ok; e.errc = exp_err; e.led = exp_led; e.lat = (st == 5) ? -1 : n + 2;
      q.push_back(e);
      for (int i = 0; i < frm.size(); i++) send_byte(frm[i], 1'b1);
   endtask

   task automatic drain(input string name, input int budget);
      int k;
      k = 0;
      while (q.size() != 0 && k < budget) begin
         @(negedge i_clk);
         k++;
      end
      check(name, q.size(), 0);
      q.delete();
      repeat (2) @(negedge i_clk);
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      i_reset   = 1'b0;
      i_rx_dv   = 1'b0;
      i_rx_byte = 8'h00;
      repeat (3) @(negedge i_clk);
      check("rst_ok_en", int'(o_ok_mem_en), 0);
      check("rst_fail_en", int'(o_fail_mem_en), 0);
      check("rst_ok_wdone", int'(o_ok_mem_wdone), 0);
      check("rst_fail_wdone", int'(o_fail_mem_wdone), 0);
      check("rst_status", int'(o_status), 0);
      check("rst_ok_cnt", int'(o_ok_cnt), 0);
      check("rst_err_cnt", int'(o_err_cnt), 0);
      check("rst_drop_cnt", int'(o_drop_cnt), 0);
      check("rst_led", int'(o_led), 0);
      check("rst_busy", int'(o_busy), 0);
      i_reset = 1'b1;
      repeat (2) @(negedge i_clk);

      // good frame: 30^31^07^AA^BB = 17
      frm = '{8'h30, 8'h31, 8'h07, 8'hAA, 8'hBB, 8'h17, 8'h32};
      run_frame(1, 0, 7, 0);  drain("drain_ok7", 50);
      frm = '{8'h30, 8'h31, 8'h07, 8'hAA, 8'hBB, 8'h00, 8'h32};
      run_frame(0, 0, 7, 3);  drain("drain_chk", 50);
      frm = '{8'h30, 8'h31, 8'hFF};
      run_frame(0, 0, 3, 2);  drain("drain_len_ff", 50);
      frm = '{8'h30, 8'h31, 8'h04};
      run_frame(0, 0, 3, 2);  drain("drain_len_04", 50);
      frm = '{8'h30, 8'h31, 8'h07, 8'hAA};
      run_frame(0, 0, 4, 5);  drain("drain_tmo", 100);
      frm = '{8'h55, 8'h30, 8'h44};
      run_frame(0, 1, 2, 1);  drain("drain_hdr", 50);
      // bad trailer and bad checksum together: trailer wins
      frm = '{8'h30, 8'h31, 8'h05, 8'h00, 8'h33};
      run_frame(0, 0, 5, 4);  drain("drain_trl", 50);
      // minimum length: chk = 30^31^05 = 04
      frm = '{8'h30, 8'h31, 8'h05, 8'h04, 8'h32};
      run_frame(1, 0, 5, 0);  drain("drain_min", 50);
      // HDR0 inside payload: chk = 30^31^08^30^30^30 = 39
      frm = '{8'h30, 8'h31, 8'h08, 8'h30, 8'h30, 8'h30, 8'h39, 8'h32};
      run_frame(1, 0, 8, 0);  drain("drain_hdr0_body", 50);
      // maximum length 100 with zero payload: chk = 30^31^64 = 65
      frm = '{8'h30, 8'h31, 8'h64};
      for (int i = 0; i < 95; i++) frm.push_back(8'h00);
      frm.push_back(8'h65);
      frm.push_back(8'h32);
      run_frame(1, 0, 100, 0);  drain("drain_max", 300);
      frm = '{8'h30, 8'h31, 8'h65};
      run_frame(0, 0, 3, 2);  drain("drain_over_max", 50);

      // bytes arriving during a copy are dropped
      frm = '{8'h30, 8'h31, 8'h07, 8'hAA, 8'hBB, 8'h17, 8'h32};
      run_frame(1, 0, 7, 0);
      send_byte(8'h30, 1'b0);
      check("busy_during_copy", int'(o_busy), 1);
      send_byte(8'h31, 1'b0);
      send_byte(8'h07, 1'b0);
      drain("drain_drop", 50);
      check("drop_cnt", int'(o_drop_cnt), 3);
      check("idle_busy", int'(o_busy), 0);

      // reset in the middle of a copy: everything clears, no done pulse
      mon_off = 1'b1;
      for (int i = 0; i < frm.size(); i++) send_byte(frm[i], 1'b0);
      repeat (4) @(negedge i_clk);
      check("midcopy_ok_en", int'(o_ok_mem_en), 1);
      i_reset = 1'b0;
      #1;
      check("mrst_ok_en", int'(o_ok_mem_en), 0);
      check("mrst_ok_wen", int'(o_ok_mem_wen), 0);
      check("mrst_busy", int'(o_busy), 0);
      check("mrst_ok_cnt", int'(o_ok_cnt), 0);
      check("mrst_err_cnt", int'(o_err_cnt), 0);
      check("mrst_drop_cnt", int'(o_drop_cnt), 0);
      check("mrst_led", int'(o_led), 0);
      repeat (12) @(negedge i_clk);
      i_reset = 1'b1;
      repeat (10) @(negedge i_clk);
      check("no_stray_wdone", stray_done, 0);
      mon_off = 1'b0;
      exp_ok  = 0;
      exp_err = 0;
      exp_led = 0;
      run_frame(1, 0, 7, 0);  drain("drain_after_rst", 50);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
